// File: rtl/bram_vector_writer.sv
// bram_vector_writer: streams a packed vector of W-bit elements into the
// shared BRAM, one element per clock, starting at BASE_ADDR. BRAM strobes
// are Moore outputs decoded from state/counter so a reset drops them at once.
// Optional macro WRITE_VERIFY_EN adds a readback pass that compares every
// element and raises a sticky verify_err on any mismatch.
module bram_vector_writer #(
   parameter int IN_SIZE       = 1,
   parameter int OUT_SIZE      = 8,
   parameter int W             = 8,
   parameter int TOTAL_WEIGHTS = IN_SIZE * OUT_SIZE,
   parameter int ADDR_WIDTH    = 15,
   parameter int BASE_ADDR     = 16400
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [TOTAL_WEIGHTS*W-1:0]  data_in,
   output logic                        busy,
   output logic                        done,
   output logic                        bram_en,
   output logic                        bram_wen,
   output logic                        bram_ren,
   output logic [ADDR_WIDTH-1:0]       bram_addr,
   output logic [W-1:0]                bram_din,
   input  logic [W-1:0]                bram_dout,
   output logic                        verify_err
);

   // Counter spans the write pass and the verify pass (reads plus 2 latency cycles).
   localparam int CW = $clog2(TOTAL_WEIGHTS + 2);
   localparam logic [CW-1:0]         LAST_WR = CW'(TOTAL_WEIGHTS - 1);
   localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WRITE  = 2'd1,
`ifdef WRITE_VERIFY_EN
      S_VERIFY = 2'd2,
`endif
      S_DONE   = 2'd3
   } state_t;

   state_t                       state, state_n;
   logic [CW-1:0]                cnt, cnt_n;
   logic [TOTAL_WEIGHTS*W-1:0]   shadow;
   logic                         load;
   logic                         verr, verr_n;

`ifdef WRITE_VERIFY_EN
   localparam logic [CW-1:0] N_EL    = CW'(TOTAL_WEIGHTS);
   localparam logic [CW-1:0] TWO     = CW'(2);
   localparam logic [CW-1:0] LAST_VF = CW'(TOTAL_WEIGHTS + 1);
`else
   logic dout_unused;
   assign dout_unused = ^bram_dout;
`endif

   // State, counter, shadow vector and sticky verify flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         shadow <= '0;
         verr   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         verr  <= verr_n;
         if (load) shadow <= data_in;
      end
   end

   // Next-state logic and BRAM strobe / status decode.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      load      = 1'b0;
      verr_n    = verr;
      busy      = 1'b0;
      done      = 1'b0;
      bram_en   = 1'b0;
      bram_wen  = 1'b0;
      bram_ren  = 1'b0;
      bram_addr = BASE + ADDR_WIDTH'(cnt);
      bram_din  = '0;
      case (state)
         S_IDLE, S_DONE: begin
            done = (state == S_DONE);
            if (start) begin
               load    = 1'b1;
               verr_n  = 1'b0;
               cnt_n   = '0;
               state_n = S_WRITE;
            end
         end
         S_WRITE: begin
            busy     = 1'b1;
            bram_en  = 1'b1;
            bram_wen = 1'b1;
            bram_din = shadow[cnt*W +: W];
            if (cnt == LAST_WR) begin
               cnt_n = '0;
`ifdef WRITE_VERIFY_EN
               state_n = S_VERIFY;
`else
               state_n = S_DONE;
`endif
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
`ifdef WRITE_VERIFY_EN
         // Reads issue for cnt < N; data for read j is checked when cnt = j+2.
         S_VERIFY: begin
            busy = 1'b1;
            if (cnt < N_EL) begin
               bram_en  = 1'b1;
               bram_ren = 1'b1;
            end
            if (cnt >= TWO && bram_dout != shadow[(cnt - TWO)*W +: W])
               verr_n = 1'b1;
            if (cnt == LAST_VF) begin
               cnt_n   = '0;
               state_n = S_DONE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
`endif
         default: state_n = S_IDLE;
      endcase
   end

`ifdef WRITE_VERIFY_EN
   assign verify_err = verr;
`else
   assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_bram_vector_writer.sv
// Self-checking bench for bram_vector_writer: scoreboarded BRAM writes,
// done/busy timing, ignored start, reset mid-pass, address wrap, loopback
// and (with WRITE_VERIFY_EN) readback error detection.
module tb_bram_vector_writer;

   localparam int T = 8;
`ifdef WRITE_VERIFY_EN
   localparam int DONE_LAT = 2*T + 2;
`else
   localparam int DONE_LAT = T;
`endif

   typedef struct packed {
      logic [14:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [63:0] data_in;
   logic        busy, done, bram_en, bram_wen, bram_ren, verify_err;
   logic [14:0] bram_addr;
   logic [7:0]  bram_din;
   logic [7:0]  bram_dout = 8'h00;
   logic [7:0]  rd_stage  = 8'h00;

   logic        start_w;
   logic [31:0] data_w;
   logic        busy_w, done_w, en_w, wen_w, ren_w, verr_w;
   logic [14:0] addr_w;
   logic [7:0]  din_w;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int wr_cnt_w = 0;
   logic corrupt = 1'b0;

   wr_t exp_q[$];
   wr_t exp_wq[$];
   wr_t e_m, e_w;
   logic [7:0] mem [0:32767];

   always #5 clk = ~clk;

   bram_vector_writer #(.IN_SIZE(1), .OUT_SIZE(8), .W(8), .ADDR_WIDTH(15), .BASE_ADDR(16400)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
      .busy(busy), .done(done), .bram_en(bram_en), .bram_wen(bram_wen), .bram_ren(bram_ren),
      .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout), .verify_err(verify_err)
   );

   bram_vector_writer #(.IN_SIZE(1), .OUT_SIZE(4), .W(8), .ADDR_WIDTH(15), .BASE_ADDR(32766)) u_wrap (
      .clk(clk), .rst_n(rst_n), .start(start_w), .data_in(data_w),
      .busy(busy_w), .done(done_w), .bram_en(en_w), .bram_wen(wen_w), .bram_ren(ren_w),
      .bram_addr(addr_w), .bram_din(din_w), .bram_dout(8'h00), .verify_err(verr_w)
   );

   // BRAM model: writes land at the edge, reads return 2 cycles after the address.
   always @(posedge clk) begin
      if (bram_en && bram_wen) mem[bram_addr] <= bram_din;
      if (bram_en && bram_ren)
         rd_stage <= (corrupt && bram_addr == 15'd16403) ? 8'h00 : mem[bram_addr];
      else
         rd_stage <= 8'h00;
      bram_dout <= rd_stage;
   end

   // Scoreboard for the main instance's writes.
   always @(negedge clk) begin
      if (bram_en && bram_wen) begin
         wr_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected: addr=%0d din=%h, no write expected", bram_addr, bram_din);
         end else begin
            e_m = exp_q.pop_front();
            if (bram_addr !== e_m.addr || bram_din !== e_m.data) begin
               errors++;
               $display("FAIL write_data: got addr=%0d din=%h, expected addr=%0d din=%h",
                        bram_addr, bram_din, e_m.addr, e_m.data);
            end
         end
      end
   end

   // Scoreboard for the wrap instance's writes.
   always @(negedge clk) begin
      if (en_w && wen_w) begin
         wr_cnt_w++;
         checks++;
         if (exp_wq.size() == 0) begin
            errors++;
            $display("FAIL wrap_unexpected: addr=%0d din=%h, no write expected", addr_w, din_w);
         end else begin
            e_w = exp_wq.pop_front();
            if (addr_w !== e_w.addr || din_w !== e_w.data) begin
               errors++;
               $display("FAIL wrap_write: got addr=%0d din=%h, expected addr=%0d din=%h",
                        addr_w, din_w, e_w.addr, e_w.data);
            end
         end
      end
   end

   // Queue the expected writes, present the vector and pulse start across edge k.
   task automatic start_pass(input logic [63:0] vec);
      for (int i = 0; i < T; i++) begin
         wr_t e;
         e.addr = 15'(16400 + i);
         e.data = vec[i*8 +: 8];
         exp_q.push_back(e);
      end
      @(negedge clk);
      data_in = vec;
      start   = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int i;
      for (i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done === 1'b1) break;
      end
      checks++;
      if (i == 200) begin
         errors++;
         $display("FAIL %s_timeout: done=%b after 200 cycles, required 1", name, done);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; data_in = '0; start_w = 1'b0; data_w = '0;
      #3;
      checks++;
      if ({busy, done, bram_en, bram_wen, bram_ren, verify_err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: busy/done/en/wen/ren/verr=%b, required 000000",
                  {busy, done, bram_en, bram_wen, bram_ren, verify_err});
      end
      checks++;
      if (bram_addr !== 15'd16400 || bram_din !== 8'h00) begin
         errors++;
         $display("FAIL reset_bus: addr=%0d din=%h, required 16400 00", bram_addr, bram_din);
      end
      checks++;
      if (addr_w !== 15'd32766) begin
         errors++;
         $display("FAIL reset_wrap_addr: addr=%0d, required 32766", addr_w);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic_write;
      int base = wr_cnt;
      start_pass(64'h0807060504030201);
      for (int i = 0; i < DONE_LAT; i++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_cycle%0d: busy=%b done=%b, required 1 0", i, busy, done);
         end
`ifndef WRITE_VERIFY_EN
         checks++;
         if (bram_ren !== 1'b0 || verify_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_ren_tied: ren=%b verr=%b, required 0 0", bram_ren, verify_err);
         end
`endif
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b1 || busy !== 1'b0 || bram_en !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_hold%0d: done=%b busy=%b en=%b, required 1 0 0", i, done, busy, bram_en);
         end
      end
      checks++;
      if (wr_cnt - base != T || exp_q.size() != 0) begin
         errors++;
         $display("FAIL basic_count: writes=%0d pending=%0d, required 8 0", wr_cnt - base, exp_q.size());
      end
   endtask

   task automatic test_ignored_start;
      int base = wr_cnt;
      start_pass(64'h8877665544332211);
      repeat (3) @(negedge clk);
      start   = 1'b1;
      data_in = '1;
      @(negedge clk);
      start = 1'b0;
      wait_done("ignored");
      repeat (3) @(negedge clk);
      checks++;
      if (wr_cnt - base != T || exp_q.size() != 0) begin
         errors++;
         $display("FAIL ignored_count: writes=%0d pending=%0d, required 8 0", wr_cnt - base, exp_q.size());
      end
   endtask

   task automatic test_reset_mid_pass;
      int base = wr_cnt;
      start_pass(64'h1122334455667788);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bram_en, bram_wen, bram_ren, busy, done} !== 5'b0 || bram_addr !== 15'd16400) begin
         errors++;
         $display("FAIL midreset_strobes: en/wen/ren/busy/done=%b addr=%0d, required 00000 16400",
                  {bram_en, bram_wen, bram_ren, busy, done}, bram_addr);
      end
      checks++;
      if (wr_cnt - base != 4) begin
         errors++;
         $display("FAIL midreset_partial: writes=%0d, required 4", wr_cnt - base);
      end
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      checks++;
      if (wr_cnt - base != 4 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_quiet: writes=%0d busy=%b, required 4 0", wr_cnt - base, busy);
      end
      base = wr_cnt;
      start_pass(64'hCAFEBABE12345678);
      wait_done("rewrite");
      checks++;
      if (wr_cnt - base != T || exp_q.size() != 0) begin
         errors++;
         $display("FAIL rewrite_count: writes=%0d pending=%0d, required 8 0", wr_cnt - base, exp_q.size());
      end
   endtask

   task automatic test_address_wrap;
      logic [14:0] a [4];
      int i;
      a[0] = 15'd32766; a[1] = 15'd32767; a[2] = 15'd0; a[3] = 15'd1;
      data_w = 32'h44332211;
      for (int j = 0; j < 4; j++) exp_wq.push_back({a[j], data_w[j*8 +: 8]});
      @(negedge clk);
      start_w = 1'b1;
      @(negedge clk);
      start_w = 1'b0;
      for (i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done_w === 1'b1) break;
      end
      checks++;
      if (i == 100 || wr_cnt_w != 4 || exp_wq.size() != 0) begin
         errors++;
         $display("FAIL wrap_pass: done=%b writes=%0d pending=%0d, required 1 4 0", done_w, wr_cnt_w, exp_wq.size());
      end
   endtask

   task automatic test_loopback;
      logic [63:0] vec = 64'hFE017F80FF003CA5;
      logic [63:0] rb;
      start_pass(vec);
      wait_done("loopback");
      @(negedge clk);
      for (int i = 0; i < T; i++) rb[i*8 +: 8] = mem[15'(16400 + i)];
      checks++;
      if (rb !== vec) begin
         errors++;
         $display("FAIL loopback: loader read %h, required %h", rb, vec);
      end
   endtask

`ifdef WRITE_VERIFY_EN
   task automatic test_verify;
      corrupt = 1'b1;
      start_pass(64'h0807060504030201);
      for (int i = 0; i < DONE_LAT; i++) begin
         @(negedge clk);
         checks++;
         if (verify_err !== (i >= 14)) begin
            errors++;
            $display("FAIL verify_err_cycle%0d: verify_err=%b, required %0d", i, verify_err, (i >= 14));
         end
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || verify_err !== 1'b1) begin
         errors++;
         $display("FAIL verify_at_done: done=%b verify_err=%b, required 1 1", done, verify_err);
      end
      corrupt = 1'b0;
      start_pass(64'h0102030405060708);
      @(negedge clk);
      checks++;
      if (verify_err !== 1'b0) begin
         errors++;
         $display("FAIL verify_clear: verify_err=%b, required 0", verify_err);
      end
      wait_done("verify_clean");
      checks++;
      if (verify_err !== 1'b0) begin
         errors++;
         $display("FAIL verify_clean: verify_err=%b, required 0", verify_err);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_write();
      test_ignored_start();
      test_reset_mid_pass();
      test_address_wrap();
      test_loopback();
`ifdef WRITE_VERIFY_EN
      test_verify();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule

// File: doc/bram_vector_writer.md
Name: bram_vector_writer

Overview:
- Writes a flat packed vector of W-bit elements, such as a layer bias or result vector, into the shared BRAM.
- Writes one element per clock to consecutive addresses starting at BASE_ADDR.
- This is the write-side counterpart of the layer loaders, which read the same address windows back into packed vectors.
- Drives BRAM port signals as outputs, so the top level can arbitrate the BRAM between loaders and this writer.

Parameters:
- IN_SIZE, 1: input dimension of the layer whose vector is stored.
- OUT_SIZE, 8: output dimension of that layer.
- W, 8: element width in bits; equals the BRAM data width.
- TOTAL_WEIGHTS, IN_SIZE*OUT_SIZE: number of elements written.
- ADDR_WIDTH, 15: BRAM address width.
- BASE_ADDR, 16400: BRAM address of element 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a write pass; sampled only in IDLE or DONE.
- data_in  input  TOTAL_WEIGHTS*W  packed vector; element i = data_in[i*W +: W].
- busy  output  1  high while a pass is in progress.
- done  output  1  high in DONE; held until the next accepted start or reset.
- bram_en  output  1  BRAM enable.
- bram_wen  output  1  BRAM write enable.
- bram_ren  output  1  BRAM read enable; used only with WRITE_VERIFY_EN.
- bram_addr  output  ADDR_WIDTH  BRAM address.
- bram_din  output  W  BRAM write data.
- bram_dout  input  W  BRAM read data, valid 2 cycles after a read address is presented.
- verify_err  output  1  sticky readback mismatch flag.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done, bram_en, bram_wen, bram_ren, verify_err = 0.
  - bram_addr=BASE_ADDR, bram_din=0.
  - Internal counter and shadow register cleared.
  - Reset mid-pass abandons the pass immediately; no further BRAM strobes are issued after release.
- States: IDLE, WRITE, VERIFY (macro only), DONE.
- IDLE/DONE, start=1 at edge k:
  - Capture data_in into the shadow register; clear done and verify_err.
  - Set busy=1; counter=0; go to WRITE.
  - data_in changes after edge k do not affect the pass.
- WRITE:
  - In the cycle after edge k+i, outputs are bram_en=1, bram_wen=1, bram_addr=BASE_ADDR+i, bram_din=shadow element i, for i=0..TOTAL_WEIGHTS-1.
  - Exactly TOTAL_WEIGHTS write cycles, back to back.
  - After the last write: go to DONE, or to VERIFY when the macro is defined.
- DONE:
  - bram_en=bram_wen=bram_ren=0, busy=0, done=1.
  - Without the macro, done first asserts in the cycle after edge k+TOTAL_WEIGHTS.
- start while busy: ignored. No queuing, no restart.
- start held high in DONE: a new pass starts on that edge. done drops for the duration of the pass.
- Address arithmetic is modulo 2^ADDR_WIDTH; BASE_ADDR+i wraps silently.
- Element order is identical to the loaders, so a loader reading the same window reproduces data_in exactly.
- TOTAL_WEIGHTS=1: a single write cycle, then DONE.

Optional Feature:
- Macro: WRITE_VERIFY_EN.
- Defined:
  - After WRITE, enter VERIFY and issue TOTAL_WEIGHTS back-to-back reads: bram_en=1, bram_ren=1, bram_wen=0, bram_addr=BASE_ADDR+j.
  - Compare bram_dout 2 cycles after each read address against shadow element j.
  - Any mismatch sets verify_err=1 (sticky until the next accepted start or reset).
  - DONE is entered after the final compare; done first asserts in the cycle after edge k+2*TOTAL_WEIGHTS+2.
- Not defined:
  - No VERIFY state; bram_ren and verify_err are tied to 0; bram_dout is ignored.

Test Plan:
- Basic write:
  - Stimulus: defaults, data_in elements 0x01..0x08 (element 0 = 0x01), start pulsed 1 cycle.
  - Required: writes to 16400..16407 with din 0x01..0x08 on 8 consecutive cycles; done asserts in the cycle after edge k+8 and holds; busy falls with it.
- Ignored start:
  - Stimulus: start re-pulsed at write cycle 3 while data_in is changed to all 0xFF.
  - Required: pass unaffected; exactly 8 writes with the original data.
- Reset mid-pass:
  - Stimulus: rst_n=0 after 4 writes.
  - Required: all strobes 0 within the same cycle; no writes after release; a new start rewrites from 16400.
- Address wrap:
  - Stimulus: BASE_ADDR=32766, TOTAL_WEIGHTS=4.
  - Required: addresses 32766, 32767, 0, 1.
- Loopback:
  - Stimulus: writer stores 0xA5,0x3C,0x00,0xFF,0x80,0x7F,0x01,0xFE; a loader then reads the same window.
  - Required: loader output equals the original data_in.
- Verify (WRITE_VERIFY_EN, BRAM model corrupts address 16403 to 0x00):
  - Required: verify_err=1, set on the fourth compare and still set at done.
  - Clean BRAM run: verify_err=0; done in the cycle after edge k+18.
